// File: rtl/trail_writer.sv
// -----------------------------------------------------------------------------
// trail_writer
// Paints the two bike trails into a 4-bit-per-pixel frame buffer (two pixels
// per 16-bit word) and repaints the whole buffer to the background colour on
// request or after reset.
//
// Ports
//   Clk                     system clock, all state on the rising edge
//   Reset                   asynchronous active-low reset
//   frame_clk               frame tick, asynchronous to Clk
//   clear_req               level request to repaint the buffer to BG_COLOR
//   Blue_X_real/Blue_Y_real blue bike pixel position
//   Red_X_real/Red_Y_real   red bike pixel position
//   blue_alive/red_alive    per-bike trail write enables
//   write_address           frame buffer word address
//   Data_Out                frame buffer write word
//   WE                      write enable, one word per cycle
//   busy                    high while the block is doing anything but idling
//   clear_done              one-cycle pulse after the last clear word
//
// All outputs are registered and are loaded from the next-state decode, so
// what they show in a cycle always belongs to the state the FSM is in during
// that cycle. This is what lets the blue write appear in the cycle right after
// the frame event and lets reset pull WE low asynchronously.
// -----------------------------------------------------------------------------
module trail_writer #(
    parameter logic [3:0]  BG_COLOR    = 4'h8,
    parameter logic [3:0]  BLUE_COLOR  = 4'h1,
    parameter logic [3:0]  RED_COLOR   = 4'h2,
    // Words in the buffer: 640 x 480 pixels, two pixels per word.
    parameter int unsigned CLEAR_WORDS = 153600
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic        clear_req,
    input  logic [9:0]  Blue_X_real,
    input  logic [9:0]  Blue_Y_real,
    input  logic [9:0]  Red_X_real,
    input  logic [9:0]  Red_Y_real,
    input  logic        blue_alive,
    input  logic        red_alive,
    output logic [18:0] write_address,
    output logic [15:0] Data_Out,
    output logic        WE,
    output logic        busy,
    output logic        clear_done
);

    typedef enum logic [1:0] {
        CLEAR   = 2'd0,
        IDLE    = 2'd1,
        WR_BLUE = 2'd2,
        WR_RED  = 2'd3
    } state_t;

    localparam logic [17:0] LAST_WORD = 18'(CLEAR_WORDS - 1);

    // Word address of pixel (x,y): x/2 + y*320, widened before the sum.
    function automatic logic [18:0] pix_addr(input logic [9:0] x, input logic [9:0] y);
        logic [18:0] xw;
        logic [18:0] yw;
        xw = {10'd0, x[9:1]};
        yw = {9'd0, y};
        return xw + (yw << 8) + (yw << 6);
    endfunction

    function automatic logic in_range(input logic [9:0] x, input logic [9:0] y);
        return (x < 10'd640) && (y < 10'd480);
    endfunction

    // Both pixel fields of a word get the same colour.
    function automatic logic [15:0] pix_word(input logic [3:0] c);
        return {4'h0, c, 4'h0, c};
    endfunction

    state_t      r_state;
    logic [17:0] r_cnt;
    logic        r_pend;
    logic        r_fs1;
    logic        r_fs2;
    logic        r_fs3;
    // Only red needs holding across a cycle; blue is consumed straight into
    // the output registers on the same edge that the frame event is taken.
    logic [9:0]  r_rx;
    logic [9:0]  r_ry;
    logic        r_ralive;

    state_t      w_state_n;
    logic [17:0] w_cnt_n;
    logic        w_pend_n;
    logic [9:0]  w_rx_n;
    logic [9:0]  w_ry_n;
    logic        w_ralive_n;
    logic [18:0] w_addr_n;
    logic [15:0] w_data_n;
    logic        w_we_n;
    logic        w_busy_n;
    logic        w_done_n;
    logic        w_frame_evt;

    // Rising edge of the synchronized frame tick.
    assign w_frame_evt = r_fs2 & ~r_fs3;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state       <= CLEAR;
            r_cnt         <= '0;
            r_pend        <= 1'b0;
            r_fs1         <= 1'b0;
            r_fs2         <= 1'b0;
            r_fs3         <= 1'b0;
            r_rx          <= '0;
            r_ry          <= '0;
            r_ralive      <= 1'b0;
            write_address <= '0;
            Data_Out      <= '0;
            WE            <= 1'b0;
            busy          <= 1'b0;
            clear_done    <= 1'b0;
        end else begin
            r_fs1         <= frame_clk;
            r_fs2         <= r_fs1;
            r_fs3         <= r_fs2;
            r_state       <= w_state_n;
            r_cnt         <= w_cnt_n;
            r_pend        <= w_pend_n;
            r_rx          <= w_rx_n;
            r_ry          <= w_ry_n;
            r_ralive      <= w_ralive_n;
            write_address <= w_addr_n;
            Data_Out      <= w_data_n;
            WE            <= w_we_n;
            busy          <= w_busy_n;
            clear_done    <= w_done_n;
        end
    end

    always_comb begin
        w_state_n  = r_state;
        w_cnt_n    = r_cnt;
        w_pend_n   = r_pend;
        w_rx_n     = r_rx;
        w_ry_n     = r_ry;
        w_ralive_n = r_ralive;
        w_addr_n   = '0;
        w_data_n   = '0;
        w_we_n     = 1'b0;
        w_done_n   = 1'b0;

        unique case (r_state)
            CLEAR: begin
                w_pend_n = 1'b0;
                if (!WE) begin
                    // First cycle out of reset: nothing written yet, so
                    // start by issuing word 0 rather than advancing.
                    w_cnt_n  = '0;
                    w_we_n   = 1'b1;
                    w_addr_n = '0;
                    w_data_n = pix_word(BG_COLOR);
                end else if (r_cnt == LAST_WORD) begin
                    w_state_n = IDLE;
                    w_cnt_n   = '0;
                    w_done_n  = 1'b1;
                end else begin
                    w_cnt_n  = r_cnt + 18'd1;
                    w_we_n   = 1'b1;
                    w_addr_n = {1'b0, w_cnt_n};
                    w_data_n = pix_word(BG_COLOR);
                end
            end

            IDLE: begin
                if (r_pend || clear_req) begin
                    w_state_n = CLEAR;
                    w_pend_n  = 1'b0;
                    w_cnt_n   = '0;
                    w_we_n    = 1'b1;
                    w_addr_n  = '0;
                    w_data_n  = pix_word(BG_COLOR);
                end else if (w_frame_evt) begin
                    w_state_n  = WR_BLUE;
                    w_rx_n     = Red_X_real;
                    w_ry_n     = Red_Y_real;
                    w_ralive_n = red_alive;
                    if (blue_alive && in_range(Blue_X_real, Blue_Y_real)) begin
                        w_we_n   = 1'b1;
                        w_addr_n = pix_addr(Blue_X_real, Blue_Y_real);
                        w_data_n = pix_word(BLUE_COLOR);
                    end
                end
            end

            WR_BLUE: begin
                if (clear_req) begin
                    w_pend_n = 1'b1;
                end
                w_state_n = WR_RED;
                if (r_ralive && in_range(r_rx, r_ry)) begin
                    w_we_n   = 1'b1;
                    w_addr_n = pix_addr(r_rx, r_ry);
                    w_data_n = pix_word(RED_COLOR);
                end
            end

            WR_RED: begin
                if (clear_req) begin
                    w_pend_n = 1'b1;
                end
                w_state_n = IDLE;
            end

            default: begin
                w_state_n = CLEAR;
                w_cnt_n   = '0;
            end
        endcase

        w_busy_n = (w_state_n != IDLE);
    end

endmodule

// File: tb/tb_trail_writer.sv
module tb_trail_writer;

    localparam int W = 1200;
    localparam logic [3:0] BG   = 4'h8;
    localparam logic [3:0] BLUE = 4'h1;
    localparam logic [3:0] RED  = 4'h2;

    logic        Clk;
    logic        Reset;
    logic        frame_clk;
    logic        clear_req;
    logic [9:0]  Blue_X_real, Blue_Y_real, Red_X_real, Red_Y_real;
    logic        blue_alive, red_alive;
    logic [18:0] write_address;
    logic [15:0] Data_Out;
    logic        WE, busy, clear_done;

    trail_writer #(
        .BG_COLOR(BG), .BLUE_COLOR(BLUE), .RED_COLOR(RED), .CLEAR_WORDS(W)
    ) dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .clear_req(clear_req),
        .Blue_X_real(Blue_X_real), .Blue_Y_real(Blue_Y_real),
        .Red_X_real(Red_X_real), .Red_Y_real(Red_Y_real),
        .blue_alive(blue_alive), .red_alive(red_alive),
        .write_address(write_address), .Data_Out(Data_Out), .WE(WE),
        .busy(busy), .clear_done(clear_done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Expected output per cycle; cycles with no entry expect an idle block.
    typedef struct {
        bit          we;
        int          a;
        logic [15:0] d;
        bit          bsy;
        bit          done;
    } ent_t;

    ent_t        exp_tab[int];
    logic [15:0] model_mem[int];
    logic [15:0] dut_mem[int];
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    function automatic logic [15:0] word_of(input logic [3:0] c);
        return {4'h0, c, 4'h0, c};
    endfunction

    function automatic void add_ent(input int c, input bit we, input int a,
                                    input logic [15:0] d, input bit bsy, input bit done);
        ent_t e;
        e.we = we; e.a = a; e.d = d; e.bsy = bsy; e.done = done;
        exp_tab[c] = e;
        if (we) model_mem[a] = d;
    endfunction

    // A clear whose word 0 appears in cycle s.
    function automatic void add_clear(input int s);
        for (int i = 0; i < W; i++) add_ent(s + i, 1'b1, i, word_of(BG), 1'b1, 1'b0);
        add_ent(s + W, 1'b0, 0, 16'h0, 1'b0, 1'b1);
    endfunction

    task automatic check(input string name, input bit ok, input string got, input string want);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %s, required %s", name, got, want);
        end
    endtask

    // Per-cycle comparison against the expectation table.
    always @(negedge Clk) begin : cmp
        ent_t e;
        bit   ok;
        if (!Reset) begin
            ok = (WE === 1'b0) && (busy === 1'b0) && (clear_done === 1'b0) &&
                 (write_address === 19'd0) && (Data_Out === 16'h0);
            e.we = 0; e.a = 0; e.d = 0; e.bsy = 0; e.done = 0;
        end else begin
            if (exp_tab.exists(cyc)) e = exp_tab[cyc];
            else begin e.we = 0; e.a = 0; e.d = 0; e.bsy = 0; e.done = 0; end
            ok = (WE === e.we) && (busy === e.bsy) && (clear_done === e.done);
            if (e.we) ok = ok && (write_address === 19'(e.a)) && (Data_Out === e.d);
            if (WE === 1'b1) dut_mem[int'(write_address)] = Data_Out;
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL cycle %0d rst_n=%0b: got WE=%0b addr=%0d data=%h busy=%0b done=%0b, required WE=%0b addr=%0d data=%h busy=%0b done=%0b",
                     cyc, Reset, WE, write_address, Data_Out, busy, clear_done,
                     e.we, e.a, e.d, e.bsy, e.done);
        end
    end

    task automatic step();
        @(negedge Clk);
        #1;
    endtask

    task automatic goto(input int n);
        while (cyc < n) step();
    endtask

    // One frame transaction started in the current cycle c.
    // mode: 0 none, 1 clear_req during WR_BLUE, 2 clear_req during WR_RED.
    // lit: 1/2 selects hand-computed literal expectations.
    task automatic do_frame(input int bx, input int by, input int rx, input int ry,
                            input bit ba, input bit ra, input int mode, input int lit);
        int c;
        bit okb, okr;
        c = cyc;
        Blue_X_real = 10'(bx); Blue_Y_real = 10'(by);
        Red_X_real  = 10'(rx); Red_Y_real  = 10'(ry);
        blue_alive = ba; red_alive = ra;
        frame_clk = 1'b1;
        okb = ba && (bx < 640) && (by < 480);
        okr = ra && (rx < 640) && (ry < 480);
        add_ent(c + 3, okb, bx / 2 + by * 320, word_of(BLUE), 1'b1, 1'b0);
        add_ent(c + 4, okr, rx / 2 + ry * 320, word_of(RED), 1'b1, 1'b0);
        goto(c + 3);
        if (lit == 1)
            check("blue_lit", WE === 1'b1 && write_address === 19'd16050 && Data_Out === 16'h0101,
                  $sformatf("WE=%0b addr=%0d data=%h", WE, write_address, Data_Out), "WE=1 addr=16050 data=0101");
        if (lit == 2)
            check("blue_oob", WE === 1'b0, $sformatf("WE=%0b", WE), "WE=0");
        frame_clk = 1'b0;
        // Inputs moving after the frame event must not affect the red write.
        Red_X_real = 10'($urandom_range(0, 1023)); Red_Y_real = 10'($urandom_range(0, 1023));
        Blue_X_real = 10'($urandom_range(0, 1023)); red_alive = ~ra;
        if (mode == 1) clear_req = 1'b1;
        goto(c + 4);
        if (lit == 1)
            check("red_lit", WE === 1'b1 && write_address === 19'd19250 && Data_Out === 16'h0202,
                  $sformatf("WE=%0b addr=%0d data=%h", WE, write_address, Data_Out), "WE=1 addr=19250 data=0202");
        if (lit == 2)
            check("red_dead", WE === 1'b0, $sformatf("WE=%0b", WE), "WE=0");
        clear_req = (mode == 2);
        goto(c + 5);
        if (lit != 0)
            check("idle_n3", WE === 1'b0 && busy === 1'b0,
                  $sformatf("WE=%0b busy=%0b", WE, busy), "WE=0 busy=0");
        clear_req = 1'b0;
        if (mode != 0) begin
            add_clear(c + 6);
            goto(c + 6 + W + 2);
        end else begin
            goto(c + 6);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int d;
        int mism;
        Reset = 1'b0; frame_clk = 1'b0; clear_req = 1'b0;
        Blue_X_real = '0; Blue_Y_real = '0; Red_X_real = '0; Red_Y_real = '0;
        blue_alive = 1'b0; red_alive = 1'b0;

        // Power-up clear.
        goto(2);
        Reset = 1'b1;
        add_clear(cyc + 1);
        goto(3 + W + 3);

        // Directed frames.
        do_frame(100, 50, 101, 60, 1'b1, 1'b1, 0, 1);
        do_frame(640, 10, 300, 200, 1'b1, 1'b0, 0, 2);

        // Held clear_req: back-to-back clears, frame tick inside a clear dropped.
        d = cyc;
        clear_req = 1'b1;
        add_clear(d + 1);
        add_clear(d + W + 2);
        goto(d + 50);  frame_clk = 1'b1;
        goto(d + 60);  frame_clk = 1'b0;
        goto(d + W + 10); clear_req = 1'b0;
        goto(d + 2 * W + 6);

        // Randomized frames, with clears pulsed inside WR_BLUE and WR_RED.
        for (int i = 0; i < 30; i++) begin
            int md;
            md = (i == 5) ? 1 : ((i == 17) ? 2 : 0);
            do_frame($urandom_range(0, 719), $urandom_range(0, 519),
                     $urandom_range(0, 719), $urandom_range(0, 519),
                     ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), md, 0);
            goto(cyc + $urandom_range(0, 3));
        end

        // Reset in the middle of a clear.
        d = cyc;
        clear_req = 1'b1;
        add_clear(d + 1);
        step();
        clear_req = 1'b0;
        goto(d + 1001);
        check("pre_rst_addr", WE === 1'b1 && write_address === 19'd1000,
              $sformatf("WE=%0b addr=%0d", WE, write_address), "WE=1 addr=1000");
        #1 Reset = 1'b0;
        exp_tab.delete();
        #1;
        check("async_we_drop", WE === 1'b0, $sformatf("WE=%0b", WE), "WE=0");
        step(); step(); step();
        Reset = 1'b1;
        add_clear(cyc + 1);
        step();
        check("restart_addr0", WE === 1'b1 && write_address === 19'd0,
              $sformatf("WE=%0b addr=%0d", WE, write_address), "WE=1 addr=0");
        goto(cyc + W + 4);

        // Both bikes on the same word: red must be the final content.
        do_frame(20, 5, 21, 5, 1'b1, 1'b1, 0, 0);
        goto(cyc + 4);

        check("same_word", dut_mem.exists(1610) && dut_mem[1610] === 16'h0202,
              $sformatf("%h", dut_mem.exists(1610) ? dut_mem[1610] : 16'hxxxx), "0202");

        mism = 0;
        foreach (model_mem[k])
            if (!dut_mem.exists(k) || dut_mem[k] !== model_mem[k]) mism++;
        if (dut_mem.size() != model_mem.size()) mism++;
        check("mem_image", mism == 0, $sformatf("%0d differing words", mism), "0 differing words");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
